// File: rtl/rrb_ingress_buf.sv
// -----------------------------------------------------------------------------
// rrb_ingress_buf
//
// Purpose:
//   Ingress side of a 4-way round-robin arbiter. Words from four sources are
//   queued in per-source FIFOs. While FIFO k holds data, req_o[k] is asserted
//   toward the arbiter. A valid one-hot grant pulse pops the granted FIFO head
//   into a single output register. The popped word is then presented on a
//   valid/ready master port, tagged with its source index.
//
// Ports:
//   clk_i       clock; every state update happens on the rising edge
//   rst_n_i     synchronous active-low reset
//   s_valid_i   per-source push request (bit k = source k)
//   s_data_i    source k word at [k*DATA_W +: DATA_W]
//   s_ready_o   per-source FIFO not full (from registered count only)
//   req_o       request vector to the arbiter (nonempty mask while in REQ)
//   grant_i     one-hot, one-cycle grant pulse from the arbiter
//   m_valid_o   output word valid
//   m_data_o    output word
//   m_src_o     source index of m_data_o
//   m_ready_i   downstream accept
//
// Optional build macro: RRB_INGRESS_ERR_EN
//   When defined, two extra outputs are added:
//     err_o       sticky flag, set the cycle after any invalid grant
//     drop_cnt_o  saturating (at 255) count of invalid grants
//
// Handshake: a word moves on a rising edge where valid and ready are both 1.
//   Source side: s_valid_i[k] & s_ready_o[k]. Master side: m_valid_o &
//   m_ready_i. Once m_valid_o is raised, it and m_data_o/m_src_o stay stable
//   until the word is accepted.
// -----------------------------------------------------------------------------
module rrb_ingress_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [3:0]          s_valid_i,
    input  logic [4*DATA_W-1:0] s_data_i,
    output logic [3:0]          s_ready_o,
    output logic [3:0]          req_o,
    input  logic [3:0]          grant_i,
    output logic                m_valid_o,
    output logic [DATA_W-1:0]   m_data_o,
    output logic [1:0]          m_src_o,
    input  logic                m_ready_i
`ifdef RRB_INGRESS_ERR_EN
    ,
    output logic                err_o,
    output logic [7:0]          drop_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q     [4][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [4];
    logic [PTR_W-1:0]  wr_ptr_d  [4];
    logic [PTR_W-1:0]  rd_ptr_q  [4];
    logic [PTR_W-1:0]  rd_ptr_d  [4];
    logic [CNT_W-1:0]  cnt_q     [4];
    logic [CNT_W-1:0]  cnt_d     [4];

    logic [3:0]        nonempty;
    logic [3:0]        full;
    logic [3:0]        push;
    logic [3:0]        pop;

    // Grant decode
    logic              grant_ok;
    logic [1:0]        grant_idx;
    logic [DATA_W-1:0] head_data;

    // FSM and output register
    state_t            state_q;
    state_t            state_d;
    logic              m_valid_q;
    logic              m_valid_d;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;
    logic [1:0]        m_src_q;
    logic [1:0]        m_src_d;

    // -------------------------------------------------------------------------
    // Status derived from registered counts only. A FIFO that is full stays
    // not-ready even if it is popped in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nonempty[k] = (cnt_q[k] != '0);
            full[k]     = (cnt_q[k] == CNT_W'(DEPTH));
            push[k]     = s_valid_i[k] & ~full[k];
        end
    end

    assign s_ready_o = ~full;
    assign req_o     = (state_q == ST_REQ) ? nonempty : 4'b0000;

    // -------------------------------------------------------------------------
    // A grant is accepted only in REQ, only when it is one-hot, and only when
    // it targets a nonempty FIFO. Anything else is ignored.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (grant_i[k]) begin
                grant_idx = 2'(k);
            end
        end
    end

    assign grant_ok  = (state_q == ST_REQ) && $onehot(grant_i) &&
                       ((grant_i & nonempty) != 4'b0000);
    assign pop       = grant_ok ? grant_i : 4'b0000;
    assign head_data = mem_q[grant_idx][rd_ptr_q[grant_idx]];

    // -------------------------------------------------------------------------
    // FIFO pointer/count next state. The pointers wrap naturally because
    // DEPTH is a power of two.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            cnt_d[k]    = cnt_q[k];
            if (push[k]) begin
                wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state: REQ waits for an accepted grant; HOLD presents the word
    // until the downstream accepts it.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;
        case (state_q)
            ST_REQ: begin
                if (grant_ok) begin
                    m_data_d  = head_data;
                    m_src_d   = grant_idx;
                    m_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_valid_q && m_ready_i) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            default: begin
                state_d   = ST_REQ;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // The data array carries no reset: an entry is only read after it has been
    // written, and the pointer/count reset makes every old entry unreachable.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= s_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            state_q   <= ST_REQ;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_src_q   <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_src_q   <= m_src_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_src_o   = m_src_q;

`ifdef RRB_INGRESS_ERR_EN
    // -------------------------------------------------------------------------
    // Invalid-grant reporting: any nonzero grant that was not accepted.
    // -------------------------------------------------------------------------
    logic       grant_bad;
    logic       err_q;
    logic       err_d;
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    assign grant_bad = (grant_i != 4'b0000) && !grant_ok;

    always_comb begin
        err_d      = err_q | grant_bad;
        drop_cnt_d = drop_cnt_q;
        if (grant_bad && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_o      = err_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rrb_ingress_buf.sv
module tb_rrb_ingress_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    // ---------------------------------------------------------------- clock/reset
    logic                clk_i = 1'b0;
    logic                rst_n_i = 1'b0;
    logic [3:0]          s_valid_i = 4'b0000;
    logic [4*DATA_W-1:0] s_data_i = '0;
    logic [3:0]          s_ready_o;
    logic [3:0]          req_o;
    logic [3:0]          grant_i = 4'b0000;
    logic                m_valid_o;
    logic [DATA_W-1:0]   m_data_o;
    logic [1:0]          m_src_o;
    logic                m_ready_i = 1'b0;
`ifdef RRB_INGRESS_ERR_EN
    logic                err_o;
    logic [7:0]          drop_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    rrb_ingress_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .req_o      (req_o),
        .grant_i    (grant_i),
        .m_valid_o  (m_valid_o),
        .m_data_o   (m_data_o),
        .m_src_o    (m_src_o),
        .m_ready_i  (m_ready_i)
`ifdef RRB_INGRESS_ERR_EN
        ,
        .err_o      (err_o),
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    // Each entry is {src[1:0], data[7:0]}
    logic [9:0] exp_q[$];
    logic [9:0] exp_w;
    int         n_tests = 0;
    int         n_fail  = 0;

    // Bench arbiter state: a registered, lowest-index-first arbiter that
    // grants one cycle after it sees a request, never back-to-back.
    logic       arb_en   = 1'b0;
    logic [3:0] arb_pend = 4'b0000;

    function automatic logic [3:0] lowest(input logic [3:0] r);
        return r & (~r + 4'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk_i) begin
        if (rst_n_i && m_valid_o && m_ready_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected: got src=%0d data=%0h, required no output",
                         m_src_o, m_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({m_src_o, m_data_o} !== exp_w) begin
                    n_fail++;
                    $display("FAIL mon_word: got src=%0d data=%0h, required src=%0d data=%0h",
                             m_src_o, m_data_o, exp_w[9:8], exp_w[7:0]);
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (arb_en) begin
            grant_i  = arb_pend;
            arb_pend = (grant_i == 4'b0000 && req_o != 4'b0000) ? lowest(req_o) : 4'b0000;
        end
    endtask

    task automatic push_words(input logic [3:0] mask, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3);
        s_valid_i = mask;
        s_data_i  = {d3, d2, d1, d0};
        tick();
        s_valid_i = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n_i   = 1'b0;
        s_valid_i = 4'b0000;
        grant_i   = 4'b0000;
        arb_pend  = 4'b0000;
        arb_en    = 1'b0;
        m_ready_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        exp_q.delete();
    endtask

    task automatic start_arb();
        grant_i  = 4'b0000;
        arb_pend = 4'b0000;
        arb_en   = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            if (m_valid_o) check({name, "_req_in_hold"}, {28'd0, req_o}, 32'h0);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d words pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_req_idle"}, {28'd0, req_o}, 32'h0);
        check({name, "_valid_idle"}, {31'd0, m_valid_o}, 32'h0);
        arb_en   = 1'b0;
        grant_i  = 4'b0000;
        arb_pend = 4'b0000;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset state
        do_reset();
        check("rst_s_ready", {28'd0, s_ready_o}, 32'hF);
        check("rst_req",     {28'd0, req_o},     32'h0);
        check("rst_m_valid", {31'd0, m_valid_o}, 32'h0);
        check("rst_m_data",  {24'd0, m_data_o},  32'h0);
        check("rst_m_src",   {30'd0, m_src_o},   32'h0);
`ifdef RRB_INGRESS_ERR_EN
        check("rst_err",  {31'd0, err_o},      32'h0);
        check("rst_drop", {24'd0, drop_cnt_o}, 32'h0);
`endif

        // 1) Single word on source 2, latency push -> valid is 3 cycles
        start_arb();
        m_ready_i = 1'b1;
        exp_q.push_back({2'd2, 8'hA5});
        push_words(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
        check("t1_req_c1",   {28'd0, req_o},     32'h4);
        check("t1_valid_c1", {31'd0, m_valid_o}, 32'h0);
        tick();
        check("t1_valid_c2", {31'd0, m_valid_o}, 32'h0);
        tick();
        check("t1_valid_c3", {31'd0, m_valid_o}, 32'h1);
        check("t1_data_c3",  {24'd0, m_data_o},  32'hA5);
        check("t1_src_c3",   {30'd0, m_src_o},   32'h2);
        check("t1_req_hold", {28'd0, req_o},     32'h0);
        wait_drain("t1", 20);

        // 2) Fill source 0, overflow push rejected, drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            push_words(4'b0001, 8'(i), 8'h00, 8'h00, 8'h00);
        end
        check("t2_full_ready", {28'd0, s_ready_o}, 32'hE);
        push_words(4'b0001, 8'h05, 8'h00, 8'h00, 8'h00);
        check("t2_after_5th_ready", {28'd0, s_ready_o}, 32'hE);
        check("t2_req",             {28'd0, req_o},     32'h1);
        for (int i = 1; i <= DEPTH; i++) exp_q.push_back({2'd0, 8'(i)});
        start_arb();
        wait_drain("t2", 40);
        check("t2_ready_after", {28'd0, s_ready_o}, 32'hF);

        // 3) One word on every source at once, drained in grant order 0..3
        push_words(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        check("t3_req_all", {28'd0, req_o}, 32'hF);
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 8'(8'h10 + k)});
        start_arb();
        wait_drain("t3", 40);

        // 4) Stall in HOLD while an invalid grant arrives
        m_ready_i = 1'b0;
        push_words(4'b1010, 8'h00, 8'h77, 8'h00, 8'h88);
        push_words(4'b0010, 8'h00, 8'h78, 8'h00, 8'h00);
        grant_i = 4'b0010;
        tick();
        grant_i = 4'b0000;
        exp_q.push_back({2'd1, 8'h77});
        for (int i = 0; i < 10; i++) begin
            if (i == 3) grant_i = 4'b0010;
            tick();
            grant_i = 4'b0000;
            check("t4_hold_data", {22'd0, m_valid_o, m_src_o, m_data_o}, {22'd0, 1'b1, 2'd1, 8'h77});
        end
`ifdef RRB_INGRESS_ERR_EN
        check("t4_err",  {31'd0, err_o},      32'h1);
        check("t4_drop", {24'd0, drop_cnt_o}, 32'h1);
`endif
        m_ready_i = 1'b1;
        exp_q.push_back({2'd1, 8'h78});
        exp_q.push_back({2'd3, 8'h88});
        start_arb();
        wait_drain("t4", 40);

        // 5) Multi-hot grant, then a grant to empty FIFO 3
        do_reset();
        push_words(4'b0011, 8'h30, 8'h31, 8'h00, 8'h00);
        grant_i = 4'b0011;
        tick();
        grant_i = 4'b1000;
        tick();
        grant_i = 4'b0000;
        tick();
        check("t5_valid", {31'd0, m_valid_o}, 32'h0);
        check("t5_req",   {28'd0, req_o},     32'h3);
`ifdef RRB_INGRESS_ERR_EN
        check("t5_err",  {31'd0, err_o},      32'h1);
        check("t5_drop", {24'd0, drop_cnt_o}, 32'h2);
`endif
        m_ready_i = 1'b1;
        exp_q.push_back({2'd0, 8'h30});
        exp_q.push_back({2'd1, 8'h31});
        start_arb();
        wait_drain("t5", 40);

        // 6) Reset while in HOLD with data buffered in three FIFOs
        m_ready_i = 1'b0;
        push_words(4'b0111, 8'h40, 8'h41, 8'h42, 8'h00);
        grant_i = 4'b0001;
        tick();
        grant_i = 4'b0000;
        tick();
        check("t6_in_hold", {31'd0, m_valid_o}, 32'h1);
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check("t6_rst_valid", {31'd0, m_valid_o}, 32'h0);
        check("t6_rst_req",   {28'd0, req_o},     32'h0);
        check("t6_rst_ready", {28'd0, s_ready_o}, 32'hF);
        check("t6_rst_data",  {24'd0, m_data_o},  32'h0);
        check("t6_rst_src",   {30'd0, m_src_o},   32'h0);
        m_ready_i = 1'b1;
        exp_q.push_back({2'd3, 8'h5A});
        start_arb();
        push_words(4'b1000, 8'h00, 8'h00, 8'h00, 8'h5A);
        wait_drain("t6", 20);

        // ------------------------------------------------------------ report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rrb_ingress_buf.md
Name: rrb_ingress_buf

Overview:
- Upstream request-generation and downstream data-return stage for the 4-way round-robin arbiter.
- Buffers words from 4 sources in per-source FIFOs and drives `req_o[k]` to the arbiter while FIFO k holds data.
- On the arbiter's one-hot grant pulse, pops the granted FIFO head into a single output register.
- Presents that word on a valid/ready master interface tagged with its source index.

Parameters:
- DATA_W, 8, width of one data word.
- DEPTH, 4, entries per source FIFO; power of 2, minimum 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset.
- s_valid_i  in  4  per-source push request; bit k = source k.
- s_data_i  in  4*DATA_W  source k word at bits [k*DATA_W +: DATA_W].
- s_ready_o  out  4  per-source FIFO not full.
- req_o  out  4  request vector to the arbiter.
- grant_i  in  4  one-hot, one-cycle registered grant pulse from the arbiter.
- m_valid_o  out  1  output word valid.
- m_data_o  out  DATA_W  output word.
- m_src_o  out  2  source index of m_data_o.
- m_ready_i  in  1  downstream accept.

Interface rule (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge):
  - All FIFOs empty, pointers 0, FSM to REQ.
  - s_ready_o=4'b1111, req_o=0, m_valid_o=0, m_data_o=0, m_src_o=0.
  - Reset mid-transfer discards all buffered and held words; no partial output.
- FIFO k:
  - Push when s_valid_i[k] & s_ready_o[k].
  - s_ready_o[k] = !full_k, from registered count only. No bypass: full with a same-cycle pop still reports not-ready.
  - Pop only on an accepted grant.
  - Simultaneous push+pop on the same FIFO keeps the count.
  - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- FSM states REQ, HOLD:
  - REQ: req_o = per-FIFO nonempty mask (combinational from registered counts).
    - On grant_i == 1<<k with FIFO k nonempty: pop head k, load m_data_o, set m_src_o=k, m_valid_o=1 next cycle, go to HOLD.
    - grant_i == 0: stay in REQ.
  - HOLD: req_o=0, m_valid_o=1, m_data_o and m_src_o stable.
    - When m_valid_o & m_ready_i: clear m_valid_o, go to REQ next cycle.
- Invalid grant is ignored with no pop and no state change. Invalid means any of:
  - multi-hot;
  - grant to an empty FIFO;
  - any grant while in HOLD.
- Latency:
  - Push at edge t → req_o high in cycle t+1 → arbiter grant in cycle t+2 → m_valid_o in cycle t+3.
  - Sustained throughput: at most one word per 3 cycles, including the 1-cycle REQ gap after a handshake.
- req_o[k] may rise while waiting for a grant (new pushes to other sources) but never falls in REQ, because pops occur only on a grant.

Optional Feature:
- Macro: RRB_INGRESS_ERR_EN.
- Defined:
  - Adds output err_o (1 bit).
  - err_o is sticky, set the cycle after any invalid grant, cleared only by reset; reset value 0.
  - Also adds output drop_cnt_o (8 bits), counting invalid grants and saturating at 255; reset value 0.
- Undefined: ports absent; invalid grants silently ignored; all other behaviour identical.

Test Plan:
- After reset, push 8'hA5 on source 2 only; bench arbiter grants 4'b0100 one cycle after req_o=4'b0100; m_ready_i=1 → m_valid_o=1 with m_data_o=8'hA5, m_src_o=2 exactly 3 cycles after the push; req_o returns to 0.
- Fill source 0 with DEPTH words (1..4), no grants → s_ready_o[0]=0 after the 4th push; a 5th push is not accepted; grants then drain 1,2,3,4 in order with m_src_o=0.
- Push one word on each of the 4 sources in the same cycle; bench arbiter grants 0,1,2,3 → outputs in grant order; req_o drops to 0 during each HOLD; final req_o=0.
- Hold m_ready_i=0 for 10 cycles in HOLD while injecting grant 4'b0010 → m_data_o stable, FIFO 1 count unchanged, err_o=1 and drop_cnt_o=1 with RRB_INGRESS_ERR_EN.
- Drive grant 4'b0011, then a grant to an empty FIFO 3 → no pop, m_valid_o stays 0; with RRB_INGRESS_ERR_EN, drop_cnt_o=2.
- Deassert rst_n_i while in HOLD with words in 3 FIFOs → next cycle m_valid_o=0, req_o=0, s_ready_o=4'b1111; a subsequent push/grant works normally.
